// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int ADDR_W         = 32;
  localparam int LINES          = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_W          = $clog2(WORDS_PER_LINE);
  localparam int IDX_W          = $clog2(LINES);
  localparam int TAG_W          = ADDR_W - 2 - OFF_W - IDX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } line_addr_t;

  // Takes the word address (byte address without its two lane bits).
  function automatic line_addr_t split_addr(input logic [ADDR_W-3:0] word_addr);
    return line_addr_t'(word_addr);
  endfunction

  function automatic logic [ADDR_W-1:0] word_byte_addr(input logic [TAG_W-1:0] tag,
                                                       input logic [IDX_W-1:0] idx,
                                                       input logic [OFF_W-1:0] off);
    return {tag, idx, off, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the cache: combinational read, clocked writes.
module dcache_array
  import dcache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_word,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_off,
  input  logic             word_we,
  input  logic [31:0]      word_wdata,
  input  logic [3:0]       word_be,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] tag_wdata,
  input  logic             valid_set,
  input  logic             valid_clr,
  input  logic             flush_all
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags  [LINES];
  logic [31:0]      words [LINES][WORDS_PER_LINE];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_word  = words[rd_idx][rd_off];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      valid <= '0;
    else if (flush_all)
      valid <= '0;
    else if (valid_clr)
      valid[wr_idx] <= 1'b0;
    else if (valid_set)
      valid[wr_idx] <= 1'b1;
  end

  // Tag and data contents are only meaningful under a valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (tag_we)
      tags[wr_idx] <= tag_wdata;
    if (word_we)
      for (int b = 0; b < 4; b++)
        if (word_be[b])
          words[wr_idx][wr_off][8*b +: 8] <= word_wdata[8*b +: 8];
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache: FSM and backing-memory handshake.
module dcache_wt
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  input  logic              flush,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]       state;
  logic [OFF_W-1:0] cnt;
  logic [OFF_W-1:0] cnt_next;
  logic             flush_pend;
  line_addr_t       held;
  line_addr_t       req_line;
  line_addr_t       cur;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_word;

  logic hit, ack, do_flush, accept, load_hit, load_miss, store, last_beat;
  logic unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  // Lookups use the live request while idle and the latched one while busy.
  assign req_line  = split_addr(req_addr[ADDR_W-1:2]);
  assign cur       = (state == S_IDLE) ? req_line : held;
  assign cnt_next  = cnt + 1'b1;

  assign ack       = mem_ack && mem_req;
  assign hit       = rd_valid && (rd_tag == cur.tag);
  assign do_flush  = flush || flush_pend;
  assign accept    = (state == S_IDLE) && req_valid && !do_flush;
  assign load_hit  = accept && !req_we && hit;
  assign load_miss = accept && !req_we && !hit;
  assign store     = accept && req_we;
  assign last_beat = (state == S_REFILL) && ack && (cnt == OFF_W'(WORDS_PER_LINE - 1));

  dcache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (cur.idx),
    .rd_off     (cur.off),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_word    (rd_word),
    .wr_idx     (cur.idx),
    .wr_off     ((state == S_REFILL) ? cnt : cur.off),
    .word_we    ((store && hit) || ((state == S_REFILL) && ack)),
    .word_wdata ((state == S_REFILL) ? mem_rdata : req_wdata),
    .word_be    ((state == S_REFILL) ? 4'hF : req_be),
    .tag_we     (last_beat),
    .tag_wdata  (cur.tag),
    .valid_set  (last_beat),
    .valid_clr  (load_miss),
    .flush_all  ((state == S_IDLE) && do_flush)
  );

  // A request completes on the edge where ready is high.
  always_comb begin
    ready = 1'b0;
    if (!rst)
      ready = 1'b1;
    else begin
      case (state)
        S_IDLE:  ready = !(req_valid && (do_flush || req_we || !hit));
        S_WRITE: ready = ack;
        S_RESP:  ready = 1'b1;
        default: ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      held       <= '0;
      flush_pend <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
    end else begin
      rvalid     <= 1'b0;
      flush_pend <= (state == S_IDLE) ? 1'b0 : (flush_pend || flush);
      case (state)
        S_IDLE: begin
          if (load_hit) begin
            rdata  <= rd_word;
            rvalid <= 1'b1;
          end else if (load_miss) begin
            held     <= req_line;
            cnt      <= '0;
            state    <= S_REFILL;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= word_byte_addr(req_line.tag, req_line.idx, '0);
          end else if (store) begin
            held      <= req_line;
            state     <= S_WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= req_wdata;
            mem_be    <= req_be;
          end
        end
        S_REFILL: begin
          if (ack) begin
            cnt      <= cnt_next;
            mem_addr <= word_byte_addr(held.tag, held.idx, cnt_next);
            if (last_beat) begin
              mem_req <= 1'b0;
              state   <= S_RESP;
            end
          end
        end
        S_WRITE: begin
          if (ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          rdata  <= rd_word;
          rvalid <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
